// File: rtl/fpnorm_pkg.sv
// fpnorm_pkg: shared types and constants for the FPU normalization sequencer.
package fpnorm_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StShl,
        StShr,
        StZero,
        StDone
    } state_e;

    // Default exponent width and its two's-complement limits
    localparam int unsigned EXP_W_DEF = 8;
    localparam logic [EXP_W_DEF-1:0] EXP_MIN = {1'b1, {(EXP_W_DEF-1){1'b0}}};
    localparam logic [EXP_W_DEF-1:0] EXP_MAX = {1'b0, {(EXP_W_DEF-1){1'b1}}};

    // Width of the left-shift counter when it is exported
    localparam int unsigned SHCNT_W = 6;

endpackage

// File: rtl/fpnorm_exp.sv
// fpnorm_exp: saturating two's-complement exponent register with load, +1 and -1.
module fpnorm_exp
    import fpnorm_pkg::*;
#(
    parameter int unsigned W = EXP_W_DEF
) (
    input  logic         clk_sys,
    input  logic         clr_,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         at_min,
    output logic         at_max
);

    localparam logic [W-1:0] ValMin = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ValMax = {1'b0, {(W-1){1'b1}}};

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    assign at_min = (value_q == ValMin);
    assign at_max = (value_q == ValMax);
    assign value  = value_q;

    // Next value: load wins, otherwise step toward the limit without wrapping
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (inc && !at_max) begin
            value_d = value_q + W'(1);
        end else if (dec && !at_min) begin
            value_d = value_q - W'(1);
        end
    end

    // Exponent register
    always_ff @(posedge clk_sys or negedge clr_) begin
        if (!clr_) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/fpnorm.sv
// fpnorm: normalization sequencer for the FPU mantissa datapath.
// Optional build macro FPNORM_SHCNT_EN adds the shcnt output (left shifts performed).
module fpnorm
    import fpnorm_pkg::*;
#(
    parameter int unsigned EXP_W     = EXP_W_DEF,
    parameter int unsigned MAX_SHIFT = 39
) (
    input  logic             clk_sys,
    input  logic             clr_,
    input  logic             start,
    input  logic [EXP_W-1:0] exp_in,
    input  logic             t0_neq_t_1,
    input  logic             t0_neq_t1,
    input  logic             t0,
    input  logic             t_zero,
    output logic             sh_left,
    output logic             sh_right,
    output logic             clr_t,
    output logic             busy,
    output logic             done,
    output logic [EXP_W-1:0] exp_out,
    output logic             z_f,
    output logic             m_f,
    output logic             v_f
`ifdef FPNORM_SHCNT_EN
    ,
    output logic [SHCNT_W-1:0] shcnt
`endif
);

`ifdef FPNORM_SHCNT_EN
    localparam int unsigned CntW = SHCNT_W;
`else
    localparam int unsigned CntW = $clog2(MAX_SHIFT + 1);
`endif
    localparam logic [CntW-1:0]  CntMax   = {CntW{1'b1}};
    localparam logic [CntW-1:0]  CntLimit = CntW'(MAX_SHIFT);
    localparam logic [EXP_W-1:0] ExpMinW  = {1'b1, {(EXP_W-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              z_q, z_d;
    logic              m_q, m_d;
    logic              v_q, v_d;

    logic              exp_load;
    logic [EXP_W-1:0]  exp_load_val;
    logic              exp_inc;
    logic              exp_dec;
    logic [EXP_W-1:0]  exp_value;
    logic              at_min;
    logic              at_max;

    fpnorm_exp #(
        .W(EXP_W)
    ) u_exp (
        .clk_sys  (clk_sys),
        .clr_     (clr_),
        .load     (exp_load),
        .load_val (exp_load_val),
        .inc      (exp_inc),
        .dec      (exp_dec),
        .value    (exp_value),
        .at_min   (at_min),
        .at_max   (at_max)
    );

    // Commands decode from the registered state so reset kills them at once
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        z_d          = z_q;
        m_d          = m_q;
        v_d          = v_q;
        sh_left      = 1'b0;
        sh_right     = 1'b0;
        clr_t        = 1'b0;
        done         = 1'b0;
        exp_load     = 1'b0;
        exp_load_val = exp_in;
        exp_inc      = 1'b0;
        exp_dec      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    exp_load = 1'b1;
                    z_d      = 1'b0;
                    m_d      = 1'b0;
                    v_d      = 1'b0;
                    cnt_d    = '0;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (t0_neq_t_1) begin
                    state_d = StShr;
                end else if (t_zero || (cnt_q == CntLimit)) begin
                    state_d = StZero;
                end else if (t0_neq_t1) begin
                    state_d = StDone;
                end else begin
                    state_d = StShl;
                end
            end
            StShl: begin
                // Exponent already at its floor: give up and return zero
                if (at_min) begin
                    state_d = StZero;
                end else begin
                    sh_left = 1'b1;
                    exp_dec = 1'b1;
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                    state_d = StCheck;
                end
            end
            StShr: begin
                sh_right = 1'b1;
                if (at_max) begin
                    v_d = 1'b1;
                end else begin
                    exp_inc = 1'b1;
                end
                state_d = StCheck;
            end
            StZero: begin
                clr_t        = 1'b1;
                exp_load     = 1'b1;
                exp_load_val = ExpMinW;
                z_d          = 1'b1;
                m_d          = 1'b0;
                state_d      = StDone;
            end
            StDone: begin
                done = 1'b1;
                if (!z_q) begin
                    m_d = t0;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, shift counter and result flags
    always_ff @(posedge clk_sys or negedge clr_) begin
        if (!clr_) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            m_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            m_q     <= m_d;
            v_q     <= v_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign exp_out = exp_value;
    assign z_f     = z_q;
    assign m_f     = m_q;
    assign v_f     = v_q;
`ifdef FPNORM_SHCNT_EN
    assign shcnt   = cnt_q;
`endif

endmodule

// File: tb/tb_fpnorm.sv
// tb_fpnorm: random and directed bench for fpnorm with a behavioural T-register datapath.
module tb_fpnorm;

    localparam int MaxShift = 39;

    logic        clk_sys = 1'b0;
    logic        clr_    = 1'b0;
    logic        start   = 1'b0;
    logic [7:0]  exp_in  = 8'd0;
    logic        t0_neq_t_1, t0_neq_t1, t0, t_zero;
    logic        sh_left, sh_right, clr_t, busy, done;
    logic [7:0]  exp_out;
    logic        z_f, m_f, v_f;
`ifdef FPNORM_SHCNT_EN
    logic [5:0]  shcnt;
`endif

    fpnorm dut (
        .clk_sys    (clk_sys),
        .clr_       (clr_),
        .start      (start),
        .exp_in     (exp_in),
        .t0_neq_t_1 (t0_neq_t_1),
        .t0_neq_t1  (t0_neq_t1),
        .t0         (t0),
        .t_zero     (t_zero),
        .sh_left    (sh_left),
        .sh_right   (sh_right),
        .clr_t      (clr_t),
        .busy       (busy),
        .done       (done),
        .exp_out    (exp_out),
        .z_f        (z_f),
        .m_f        (m_f),
        .v_f        (v_f)
`ifdef FPNORM_SHCNT_EN
        ,
        .shcnt      (shcnt)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    // Datapath: tr[40] = T[-1], tr[39] = T[0] (sign), tr[0] = T[39]
    logic [40:0] tr;
    logic        ld_req = 1'b0;
    logic [40:0] ld_val = '0;

    always @(posedge clk_sys or negedge clr_) begin
        if (!clr_)         tr <= '0;
        else if (ld_req)   tr <= ld_val;
        else if (sh_left)  tr <= tr << 1;
        else if (sh_right) tr <= {tr[40], tr[40:1]};
        else if (clr_t)    tr <= '0;
    end

    assign t0_neq_t_1 = tr[40] ^ tr[39];
    assign t0_neq_t1  = tr[39] ^ tr[38];
    assign t0         = tr[39];
    assign t_zero     = (tr[39:0] == 40'd0);

    typedef struct {
        logic [7:0] e;
        logic       z, m, v;
        int         nl, nr, nc, lat;
    } res_t;

    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    // Expected result straight from the normalization rules
    function automatic res_t model(input logic [39:0] t, input logic g, input logic [7:0] e_in);
        res_t r;
        int   e, k, avail;
        e = sx(e_in);
        r.e = 8'd0; r.z = 1'b0; r.m = 1'b0; r.v = 1'b0;
        r.nl = 0; r.nr = 0; r.nc = 0; r.lat = 0;
        if (g != t[39]) begin
            r.nr = 1; r.m = g; r.lat = 4;
            if (e == 127) begin r.v = 1'b1; r.e = 8'd127; end
            else r.e = 8'(e + 1);
        end else if (t == 40'd0) begin
            r.z = 1'b1; r.nc = 1; r.e = 8'h80; r.lat = 3;
        end else begin
            k = 0;
            while (k < MaxShift && t[38-k] == t[39]) k++;
            avail = e + 128;
            if (k < MaxShift && k <= avail) begin
                r.nl = k; r.e = 8'(e - k); r.m = t[39]; r.lat = 2 * k + 2;
            end else begin
                r.z = 1'b1; r.nc = 1; r.e = 8'h80;
                if (avail >= MaxShift) begin r.nl = MaxShift; r.lat = 2 * MaxShift + 3; end
                else begin r.nl = avail; r.lat = 2 * avail + 4; end
            end
        end
        return r;
    endfunction

    int   checks = 0, errors = 0, cyc = 0;
    int   req_cnt = 0, ack_cnt = 0, req_start_cyc = 0;
    int   nl = 0, nr = 0, nc = 0;
    res_t req, held, p;

    task automatic chk(input string name, input int act, input int req_v);
        checks++;
        if (act != req_v) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req_v, $time);
        end
    endtask

    // Compare process: pins the model, then checks the DUT every cycle
    initial begin
        p = model(40'h4000000000, 1'b0, 8'd5);
        chk("pin_norm_exp", sx(p.e), 5);  chk("pin_norm_lat", p.lat, 2);
        chk("pin_norm_nl", p.nl, 0);
        p = model(40'h0800000000, 1'b0, 8'd0);
        chk("pin_l3_exp", sx(p.e), -3);   chk("pin_l3_nl", p.nl, 3);  chk("pin_l3_lat", p.lat, 8);
        p = model(40'h0000000000, 1'b1, 8'd10);
        chk("pin_ovf_exp", sx(p.e), 11);  chk("pin_ovf_nr", p.nr, 1);
        p = model(40'h0000000000, 1'b1, 8'd127);
        chk("pin_sat_exp", sx(p.e), 127); chk("pin_sat_v", int'(p.v), 1);
        p = model(40'h0100000000, 1'b0, 8'h81);
        chk("pin_unf_exp", sx(p.e), -128); chk("pin_unf_nl", p.nl, 1);
        chk("pin_unf_z", int'(p.z), 1);    chk("pin_unf_lat", p.lat, 6);
        p = model(40'h0000000000, 1'b0, 8'd20);
        chk("pin_zero_exp", sx(p.e), -128); chk("pin_zero_lat", p.lat, 3);
        held = p;
        held.e = 8'd0; held.z = 1'b0; held.m = 1'b0; held.v = 1'b0;
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (!clr_) begin
                chk("reset_outputs",
                    int'({sh_left, sh_right, clr_t, busy, done, exp_out, z_f, m_f, v_f}), 0);
                ack_cnt = req_cnt;
                nl = 0; nr = 0; nc = 0;
                held.e = 8'd0; held.z = 1'b0; held.m = 1'b0; held.v = 1'b0;
            end else begin
                chk("cmd_onehot0", int'($countones({sh_left, sh_right, clr_t}) <= 1), 1);
                if (req_cnt != ack_cnt) begin
                    nl += int'(sh_left); nr += int'(sh_right); nc += int'(clr_t);
                    if (done) begin
                        chk("latency", cyc - req_start_cyc, req.lat);
                        chk("exp_out", sx(exp_out), sx(req.e));
                        chk("n_sh_left", nl, req.nl);
                        chk("n_sh_right", nr, req.nr);
                        chk("n_clr_t", nc, req.nc);
                        chk("busy_at_done", int'(busy), 1);
`ifdef FPNORM_SHCNT_EN
                        chk("shcnt", int'(shcnt), req.nl);
`endif
                        held = req;
                        ack_cnt = req_cnt;
                        nl = 0; nr = 0; nc = 0;
                    end else begin
                        chk("busy_run", int'(busy), int'(cyc > req_start_cyc));
                        if (cyc - req_start_cyc > 120) begin
                            chk("done_timeout", 0, 1);
                            ack_cnt = req_cnt;
                            nl = 0; nr = 0; nc = 0;
                        end
                    end
                end else begin
                    chk("idle_quiet", int'({busy, done, sh_left, sh_right, clr_t}), 0);
                    chk("idle_exp", sx(exp_out), sx(held.e));
                    chk("idle_flags", int'({z_f, m_f, v_f}), int'({held.z, held.m, held.v}));
                end
            end
        end
    end

    task automatic run_op(input logic [39:0] t, input logic g, input logic [7:0] e,
                          input logic bump);
        @(posedge clk_sys); #1;
        ld_val = {g, t}; ld_req = 1'b1; exp_in = e;
        @(posedge clk_sys); #1;
        ld_req = 1'b0; start = 1'b1;
        req = model(t, g, e);
        req_start_cyc = cyc + 1;
        req_cnt++;
        @(posedge clk_sys); #1;
        start = 1'b0; exp_in = 8'($urandom);
        if (bump) begin
            start = 1'b1;
            @(posedge clk_sys); #1;
            start = 1'b0;
        end
        for (int i = 0; i < 300 && ack_cnt != req_cnt; i++) @(posedge clk_sys);
        if (ack_cnt != req_cnt) begin
            $display("FAIL run_op: operation never retired");
            $fatal(1);
        end
    endtask

    // Stimulus
    initial begin
        logic [39:0] t;
        logic        g, sign, bump;
        logic [7:0]  e;
        int          k;
        repeat (3) @(posedge clk_sys);
        #1 clr_ = 1'b1;

        run_op(40'h4000000000, 1'b0, 8'd5,   1'b0);
        run_op(40'h0800000000, 1'b0, 8'd0,   1'b1);
        run_op(40'h0000000000, 1'b1, 8'd10,  1'b0);
        run_op(40'h0000000000, 1'b1, 8'd127, 1'b0);
        run_op(40'h0100000000, 1'b0, 8'h81,  1'b0);
        run_op(40'h0000000000, 1'b0, 8'd20,  1'b1);
        run_op(40'hFFFFFFFFFF, 1'b1, 8'd0,   1'b0);
        run_op(40'hC000000000, 1'b1, 8'h80,  1'b0);

        for (int n = 0; n < 250; n++) begin
            sign = ($urandom_range(0, 1) != 0);
            k = $urandom_range(0, 40);
            t = {40{sign}};
            if (k < MaxShift) begin
                t[38-k] = ~sign;
                for (int j = 0; j < 38 - k; j++) t[j] = ($urandom_range(0, 1) != 0);
            end
            if ($urandom_range(0, 9) == 0) t = 40'd0;
            g = t[39];
            if ($urandom_range(0, 5) == 0) g = ~g;
            case ($urandom_range(0, 3))
                0:       e = 8'(-128 + $urandom_range(0, 45));
                1:       e = 8'(127 - $urandom_range(0, 2));
                default: e = 8'($urandom);
            endcase
            bump = ($urandom_range(0, 2) == 0);
            run_op(t, g, e, bump);
        end

        // Abort with reset while a left shift is being commanded
        @(posedge clk_sys); #1;
        ld_val = {1'b0, 40'h0000000001}; ld_req = 1'b1; exp_in = 8'd0;
        @(posedge clk_sys); #1;
        ld_req = 1'b0; start = 1'b1;
        req = model(40'h0000000001, 1'b0, 8'd0);
        req_start_cyc = cyc + 1;
        req_cnt++;
        @(posedge clk_sys); #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_sys); #1;
            if (sh_left) break;
        end
        #1 clr_ = 1'b0;
        @(posedge clk_sys); #1;
        clr_ = 1'b1;

        run_op(40'h0800000000, 1'b0, 8'd0, 1'b0);
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpnorm.md
Name: fpnorm

Overview:
- Normalization sequencer for the FPU mantissa datapath.
- After an arithmetic step it inspects the 40-bit T register status and decides the next move: right-shift once on mantissa overflow, left-shift until normalized, or declare a zero result.
- It issues one-cycle shift commands to the datapath and tracks the 8-bit exponent in lockstep.
- At the end it produces the Z/M/V flags that feed the ZP bus flag word.

Parameters:
- EXP_W, 8: exponent width, two's complement.
- MAX_SHIFT, 39: maximum left shifts before the mantissa is treated as zero.

Ports:
- clk_sys  in  1  system clock; all state changes on the rising edge.
- clr_  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; samples exp_in; ignored unless IDLE.
- exp_in  in  EXP_W  exponent before normalization.
- t0_neq_t_1  in  1  T[0] != T[-1]; mantissa overflowed into the guard bit.
- t0_neq_t1  in  1  T[0] != T[1]; mantissa is normalized.
- t0  in  1  mantissa sign.
- t_zero  in  1  high when t_0_1, t_2_7, t_8_15, t_16_23, t_24_31 and t_32_39 are all low.
- sh_left  out  1  one-cycle command: shift T left by one bit (datapath taa/trb path).
- sh_right  out  1  one-cycle command: shift T right by one bit, T[-1] into T[0].
- clr_t  out  1  one-cycle command: clear T (zero/underflow result).
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the result is final.
- exp_out  out  EXP_W  current exponent; final when done is high.
- z_f, m_f, v_f  out  1 each  zero, minus, overflow flags; held until the next start.

Behaviour:
- Reset: state IDLE. All outputs are 0, exp_out is 0, the shift counter is 0.
- Reset mid-operation aborts immediately. No command pulse may survive reset.
- States: IDLE, CHECK, SHL, SHR, ZERO, DONE.
- IDLE + start:
  - Latch exp_in.
  - Clear z_f, m_f, v_f and the shift counter.
  - Go to CHECK. busy is high next cycle.
- CHECK, evaluated in priority order:
  1. t0_neq_t_1: go to SHR.
  2. t_zero, or shift counter == MAX_SHIFT: go to ZERO.
  3. t0_neq_t1: go to DONE.
  4. Otherwise: go to SHL.
- SHL (1 cycle):
  - Assert sh_left and increment the shift counter.
  - If exp == -2^(EXP_W-1) (underflow): instead go to ZERO; no shift, exponent unchanged.
  - Otherwise exp -= 1, then return to CHECK.
- SHR (1 cycle):
  - Assert sh_right.
  - If exp == 2^(EXP_W-1)-1: set v_f and keep exp (saturate).
  - Otherwise exp += 1.
  - Go to CHECK. At most one SHR per operation; a second overflow in CHECK is impossible by construction, so the bench asserts on it.
- ZERO (1 cycle):
  - Assert clr_t.
  - exp := -2^(EXP_W-1), z_f := 1, m_f := 0.
  - Go to DONE.
- DONE (1 cycle):
  - Pulse done.
  - m_f := t0, unless z_f is set.
  - busy := 0, return to IDLE.
- Datapath contract:
  - A command asserted in cycle n is applied by the datapath at the end of cycle n.
  - CHECK in cycle n+1 sees the updated status.
  - Cost is 2 cycles per shifted bit. Worst case is 2+2*MAX_SHIFT+2 cycles.
- Exactly one of sh_left, sh_right, clr_t is high in any cycle, or none.
- start while busy is ignored, with no effect on state or flags.

Optional Feature:
- Macro: FPNORM_SHCNT_EN.
- With the macro: an extra output port shcnt [5:0] carries the number of left shifts performed. It is valid with done, cleared on start, and saturates at 63.
- Without the macro: the port is absent. The internal counter is sized only for the MAX_SHIFT comparison.

Decomposition:
- Package fpnorm_pkg holds:
  - the state enum (IDLE, CHECK, SHL, SHR, ZERO, DONE);
  - EXP_MIN and EXP_MAX constants derived from EXP_W;
  - the shift counter width.
- One sub-module, fpnorm_exp: a saturating exponent up/down register. Ports: load, inc, dec, value; flags at_min and at_max.

Test Plan:
- Already normalized: T=0x4000000000, exp_in=5, start -> CHECK then DONE; done in cycle 3, no shift pulses, exp_out=5, z_f=0, m_f=0.
- Left by 3: T=0x0800000000, exp_in=0 -> exactly 3 sh_left pulses two cycles apart, exp_out=-3, done in cycle 9.
- Overflow: t0_neq_t_1=1, exp_in=10 -> one sh_right, exp_out=11; after the datapath shift t0_neq_t1=1, then done.
- Overflow at max: exp_in=127, t0_neq_t_1=1 -> sh_right, exp_out=127, v_f=1.
- Underflow: exp_in=-127, T=0x0100000000 -> one sh_left (exp -128), then the next SHL goes to ZERO; clr_t pulses, exp_out=-128, z_f=1.
- Zero mantissa / reset abort: t_zero=1 -> clr_t, z_f=1, exp_out=-128. Separately, clr_ low during SHL -> all outputs 0 within the same cycle, state IDLE; a start during busy is ignored.
